inv_shift_rows_stream: RTL and testbench
========================================

Name: inv_shift_rows_stream

Overview:
- Byte-serial to 128-bit AES-state collector feeding the decryption datapath.
- Accepts 16 state bytes over a valid/ready byte stream, assembles a column-major state, and applies InvShiftRows (or forward ShiftRows when INVERSE=0).
- Presents the result on a 128-bit valid/ready output and holds it until taken.
- Frames with a misplaced or missing last marker are discarded and flagged.

Parameters:
- INVERSE, 1, 1 = InvShiftRows (decrypt path); 0 = forward ShiftRows (loopback/encrypt check).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- s_valid  input  1  input byte valid.
- s_ready  output  1  collector can accept a byte.
- s_byte  input  8  state byte; arrival index k=0..15.
- s_last  input  1  marks the 16th byte of a frame.
- m_valid  output  1  m_data holds a completed, transformed state.
- m_ready  input  1  downstream accepts m_data.
- m_data  output  128  transformed state.
- err  output  1  one-cycle pulse on a framing error.

Behaviour:
- Reset: one clock, synchronous, active-high; sampled on the rising edge of clk. While rst=1 and on the first cycle after release, the state is COLLECT, count=0, m_valid=0, m_data=0, err=0. s_ready=0 while rst=1.
- State layout: byte k (= 4*col + row) occupies bits [8k+7:8k]. Byte 0 is row0/col0 at bits [7:0].
- Transform, out(row,col):
  - INVERSE=1: = in(row, (col-row) mod 4).
  - INVERSE=0: = in(row, (col+row) mod 4).
  - Row 0 is unchanged. Pure byte permutation, no arithmetic.
- States: COLLECT and HOLD, plus a 4-bit byte counter cnt.
- COLLECT:
  - s_ready=1, m_valid=0.
  - Accept happens when s_valid & s_ready: s_byte is written into byte slot cnt of the staging register.
  - cnt<15 and s_last=0: cnt increments.
  - cnt<15 and s_last=1: early last. Frame discarded, cnt<=0, err pulses next cycle, stay in COLLECT.
  - cnt==15 and s_last=1: the transformed staging register (including this byte) is loaded into m_data, m_valid<=1, cnt<=0, go to HOLD.
  - cnt==15 and s_last=0: missing last. Frame discarded, cnt<=0, err pulses, stay in COLLECT.
- HOLD:
  - s_ready=0, m_valid=1. m_data stays stable until m_ready=1.
  - On m_valid & m_ready: m_valid<=0, return to COLLECT. s_ready rises the next cycle.
  - No same-cycle re-accept of input.
- Latency and throughput:
  - m_valid rises the cycle after the 16th byte is accepted.
  - Minimum 17 cycles per block with m_ready held high.
- s_valid gaps: any number of idle cycles between bytes is allowed. cnt and staging hold their values.
- Reset mid-frame or in HOLD: the partial frame or pending output is dropped, m_valid=0, cnt=0, and no err pulse.
- err: registered, asserted exactly 1 cycle per framing error, never asserted in HOLD.
- m_data after handshake: retains its last value. Only meaningful while m_valid=1.

Test Plan:
- INVERSE=1: bytes 0x00..0x0F in order, s_last on 0x0F, m_ready=1 -> m_valid on the cycle after the last byte. m_data=128'h0306090C_0F020508_0B0E0104_070A0D00, held 1 cycle.
- INVERSE=0: same stimulus -> m_data=128'h0B06010C_07020D08_030E0904_0F0A0500.
- Backpressure: m_ready=0 for 10 cycles after m_valid -> m_data stable, s_ready=0, extra s_valid bytes not consumed. m_ready=1 -> handshake, s_ready=1 next cycle. The next 16-byte frame is assembled correctly.
- Framing errors:
  - s_last on byte index 5 -> one err pulse, no m_valid. A following clean 16-byte frame produces the expected m_data.
  - 16 bytes with no s_last -> one err pulse, cnt back to 0.
- s_valid toggled 1/0 every cycle across a frame -> identical m_data to the back-to-back case.
- rst=1 after byte 8 of a frame, and separately rst=1 during HOLD -> m_valid=0, err=0. A fresh frame then yields the correct result.

Source files
------------

// File: rtl/inv_shift_rows_stream.sv
// Byte-serial AES state collector. It accepts 16 bytes over a valid/ready
// stream and builds a column-major 128-bit state, where byte k = 4*col + row
// sits at bits [8k+7:8k]. It then applies InvShiftRows (INVERSE=1) or forward
// ShiftRows (INVERSE=0) and holds the result on a valid/ready output until it
// is taken. A frame whose last marker is early or missing is dropped, and err
// pulses for one cycle.
module inv_shift_rows_stream #(
  parameter bit INVERSE = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [7:0]   s_byte,
  input  logic         s_last,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [127:0] m_data,
  output logic         err
);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [127:0]   stage_q, stage_d;
  logic [127:0]   m_data_q, m_data_d;
  logic           err_q, err_d;
  logic           accept;
  logic           last_slot;
  logic [127:0]   frame;

  // Row r is rotated by r columns: right for the inverse, left for forward.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    int           src;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = INVERSE ? ((c - r) & 3) : ((c + r) & 3);
        o[8*(4*c+r) +: 8] = s[8*(4*src+r) +: 8];
      end
    end
    return o;
  endfunction

  // Handshake, byte placement, framing checks and next-state selection.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through the block can leave a value unassigned and infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    stage_d   = stage_q;
    m_data_d  = m_data_q;
    err_d     = 1'b0;
    s_ready   = (state_q == COLLECT) && !rst;
    accept    = s_valid && s_ready;
    last_slot = (cnt_q == 4'd15);
    frame     = stage_q;
    frame[8*cnt_q +: 8] = s_byte;

    if (state_q == COLLECT) begin
      if (accept) begin
        stage_d = frame;
        if (last_slot && s_last) begin
          m_data_d = shift_rows(frame);
          cnt_d    = 4'd0;
          state_d  = HOLD;
        end else if (last_slot || s_last) begin
          // The last marker is early or missing, so the frame is discarded.
          err_d = 1'b1;
          cnt_d = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
    end else begin
      if (m_ready) begin
        state_d = COLLECT;
      end
    end
  end

  // Control and output registers. Reset clears them synchronously.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples the values that held before the clock edge.
    if (rst) begin
      state_q  <= COLLECT;
      cnt_q    <= 4'd0;
      m_data_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      m_data_q <= m_data_d;
      err_q    <= err_d;
    end
  end

  // Staging register. Every slot is rewritten before a frame can complete.
  always_ff @(posedge clk) begin
    // NOTE: the staging register is not reset. Stale contents are never observable, and leaving it out of reset keeps the reset fan-out small.
    stage_q <= stage_d;
  end

  assign m_valid = (state_q == HOLD);
  assign m_data  = m_data_q;
  assign err     = err_q;

endmodule

// File: tb/tb_inv_shift_rows_stream.sv
// Randomised self-checking bench. Two instances (inverse and forward) share
// the same stimulus. Results are compared against a row/column matrix model
// of ShiftRows and InvShiftRows.
module tb_inv_shift_rows_stream;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_valid;
  logic [7:0]   s_byte;
  logic         s_last;
  logic         m_ready;
  logic         s_ready_i, m_valid_i, err_i;
  logic         s_ready_f, m_valid_f, err_f;
  logic [127:0] m_data_i, m_data_f;

  int n_cmp = 0;
  int n_bad = 0;
  int err_pulses_i = 0;
  int err_pulses_f = 0;
  int err_in_hold = 0;

  logic [7:0]   fb [16];
  logic [127:0] last_inv, last_fwd;

  always #5 clk = ~clk;

  inv_shift_rows_stream #(.INVERSE(1'b1)) dut_inv (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_i),
    .s_byte(s_byte), .s_last(s_last), .m_valid(m_valid_i),
    .m_ready(m_ready), .m_data(m_data_i), .err(err_i)
  );

  inv_shift_rows_stream #(.INVERSE(1'b0)) dut_fwd (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_f),
    .s_byte(s_byte), .s_last(s_last), .m_valid(m_valid_f),
    .m_ready(m_ready), .m_data(m_data_f), .err(err_f)
  );

  // Count err pulses and flag any err seen while an output is held.
  always @(negedge clk) begin
    if (err_i) err_pulses_i++;
    if (err_f) err_pulses_f++;
    if ((err_i && m_valid_i) || (err_f && m_valid_f)) err_in_hold++;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: a 4x4 matrix in[row][col] whose rows are rotated.
  function automatic logic [127:0] model(input bit inv);
    logic [7:0]   m_in [4][4];
    logic [127:0] o;
    int           sc;
    for (int k = 0; k < 16; k++) m_in[k % 4][k / 4] = fb[k];
    o = '0;
    for (int row = 0; row < 4; row++) begin
      for (int col = 0; col < 4; col++) begin
        sc = inv ? ((col - row + 4) % 4) : ((col + row) % 4);
        o[8*(4*col+row) +: 8] = m_in[row][sc];
      end
    end
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one byte and wait (bounded) until it is accepted.
  task automatic send_byte(input logic [7:0] b, input logic last);
    int n = 0;
    s_valid = 1'b1;
    s_byte  = b;
    s_last  = last;
    while (!s_ready_i && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("s_ready_timeout", {127'b0, s_ready_i}, 128'd1);
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Send fb[] as one frame with random idle gaps. Optionally stall the output
  // for `hold` cycles while offering extra input bytes. Then check the result.
  task automatic do_frame(input int gmin, input int gmax, input int hold);
    logic [127:0] exp_i, exp_f;
    exp_i = model(1'b1);
    exp_f = model(1'b0);
    m_ready = (hold == 0);
    for (int k = 0; k < 16; k++) begin
      send_byte(fb[k], k == 15);
      if (k < 15) repeat ($urandom_range(gmax, gmin)) tick();
    end
    check("m_valid_rise", {126'b0, m_valid_i, m_valid_f}, 128'd3);
    check("m_data_inv", m_data_i, exp_i);
    check("m_data_fwd", m_data_f, exp_f);
    last_inv = m_data_i;
    last_fwd = m_data_f;
    for (int h = 0; h < hold; h++) begin
      s_valid = 1'b1;
      s_byte  = 8'($urandom);
      s_last  = 1'($urandom);
      tick();
      check("hold_stable", m_data_i, exp_i);
      check("hold_ready_valid", {126'b0, s_ready_i, m_valid_i}, 128'd1);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    tick();
    check("after_take", {126'b0, m_valid_i, s_ready_i}, 128'd1);
  endtask

  task automatic fill_random();
    for (int k = 0; k < 16; k++) fb[k] = 8'($urandom);
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_byte = '0; s_last = 1'b0; m_ready = 1'b1;
    tick();
    check("rst_outputs", {125'b0, s_ready_i, m_valid_i, err_i}, 128'd0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_data", m_data_i, 128'd0);
    check("post_rst_ctrl", {125'b0, s_ready_i, m_valid_i, err_i}, 128'd4);

    // Ordered bytes, back to back. Check against the fixed reference vectors.
    for (int k = 0; k < 16; k++) fb[k] = 8'(k);
    do_frame(0, 0, 0);
    check("vec_inv", last_inv, 128'h0306090C_0F020508_0B0E0104_070A0D00);
    check("vec_fwd", last_fwd, 128'h0B06010C_07020D08_030E0904_0F0A0500);

    // Backpressure: the output is stalled for 10 cycles while extra bytes are
    // offered. The frame after it must still be assembled correctly.
    fill_random();
    do_frame(0, 0, 10);
    fill_random();
    do_frame(0, 0, 0);

    // Early last on byte index 5.
    for (int k = 0; k < 6; k++) send_byte(8'($urandom), k == 5);
    check("early_err", {126'b0, err_i, m_valid_i}, 128'd2);
    tick();
    check("early_err_once", {126'b0, err_i, m_valid_i}, 128'd0);
    fill_random();
    do_frame(0, 1, 0);

    // Sixteen bytes with no last marker.
    for (int k = 0; k < 16; k++) send_byte(8'($urandom), 1'b0);
    check("missing_err", {126'b0, err_i, m_valid_i}, 128'd2);
    tick();
    check("missing_err_once", {126'b0, err_i, m_valid_i}, 128'd0);
    fill_random();
    do_frame(0, 0, 0);

    // s_valid toggled every cycle must give the same result as back to back.
    for (int k = 0; k < 16; k++) fb[k] = 8'(k);
    do_frame(1, 1, 0);
    check("toggle_inv", last_inv, 128'h0306090C_0F020508_0B0E0104_070A0D00);

    // Reset after byte index 8 of a frame.
    for (int k = 0; k < 9; k++) send_byte(8'($urandom), 1'b0);
    rst = 1'b1;
    tick();
    check("rst_mid_frame", {125'b0, s_ready_i, m_valid_i, err_i}, 128'd0);
    rst = 1'b0;
    tick();
    check("rst_mid_after", {126'b0, m_valid_i, err_i}, 128'd0);
    fill_random();
    do_frame(0, 0, 0);

    // Reset while an output is held.
    m_ready = 1'b0;
    fill_random();
    for (int k = 0; k < 16; k++) send_byte(fb[k], k == 15);
    check("hold_before_rst", {127'b0, m_valid_i}, 128'd1);
    rst = 1'b1;
    tick();
    check("rst_in_hold", {125'b0, s_ready_i, m_valid_i, err_i}, 128'd0);
    rst = 1'b0;
    tick();
    check("rst_hold_after", {126'b0, m_valid_i, err_i}, 128'd0);
    fill_random();
    do_frame(0, 0, 0);

    // Random frames with random gaps and random output stalls.
    for (int f = 0; f < 6; f++) begin
      fill_random();
      do_frame(0, 3, $urandom_range(4, 0));
    end

    tick();
    check("err_pulse_count_inv", 128'(err_pulses_i), 128'd2);
    check("err_pulse_count_fwd", 128'(err_pulses_f), 128'd2);
    check("err_in_hold", 128'(err_in_hold), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
